// File: rtl/dma_arbiter.sv
// -----------------------------------------------------------------------------
// dma_arbiter
//
// Round-robin arbiter that merges up to four DMA bus masters onto the single
// dma_req/dma_ack handshake of the MC1201-04 processor board. The granted
// device's 18-bit Unibus address and data strobe are steered to the board, and
// global_ack is routed back to that device only. A hold counter caps bus
// tenure so one controller cannot starve the others.
//
// Ports:
//   clk_p       in   1   system clock (direct phase)
//   dclo        in   1   synchronous active-high reset
//   dev_req     in   4   per-device DMA request (bit i = device i)
//   dev_gnt     out  4   one-hot per-device grant (registered)
//   dev_adr     in  72   packed addresses, device i at [18*i+17:18*i]
//   dev_stb     in   4   per-device data strobe
//   dev_ack     out  4   per-device transfer acknowledge
//   dma_req     out  1   DMA request to the board (registered)
//   dma_ack     in   1   DMA acknowledge from the board
//   dma_adr18   out 18   address of the current owner
//   dma_stb     out  1   strobe of the current owner
//   global_ack  in   1   bus/memory acknowledge
// -----------------------------------------------------------------------------
module dma_arbiter #(
    parameter int MAXHOLD = 256
) (
    input  logic        clk_p,
    input  logic        dclo,
    input  logic [3:0]  dev_req,
    output logic [3:0]  dev_gnt,
    input  logic [71:0] dev_adr,
    input  logic [3:0]  dev_stb,
    output logic [3:0]  dev_ack,
    output logic        dma_req,
    input  logic        dma_ack,
    output logic [17:0] dma_adr18,
    output logic        dma_stb,
    input  logic        global_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OWN  = 2'd2,
        S_REL  = 2'd3
    } state_t;

    // Saturation value of the tenure counter.
    localparam logic [15:0] HOLD_LAST = 16'(MAXHOLD - 1);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q,  last_d;
    logic [15:0] hold_q,  hold_d;
    logic [3:0]  gnt_q,   gnt_d;
    logic        req_q,   req_d;

    // Rotating-priority pick: first requester at last+1, last+2, ... with
    // wrap-around, so the most recent owner is considered last.
    logic [1:0] pick;
    logic       pick_valid;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a variable unassigned would infer a latch.
        pick       = 2'd0;
        pick_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] cand;
            cand = last_q + 2'(i);
            if (!pick_valid && dev_req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // A requester that gives up before the board answers is
                // dropped without ever seeing a grant; last is left unchanged
                // so it keeps its place in the rotation.
                if (!dev_req[owner_q]) begin
                    state_d = S_REL;
                end else if (dma_ack) begin
                    state_d = S_OWN;
                    gnt_d   = 4'b0001 << owner_q;
                    hold_d  = '0;
                    last_d  = owner_q;
                end
            end

            S_OWN: begin
                hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 16'd1;
                if (!dma_ack) begin
                    // Board already withdrew; no need to wait in REL.
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (!dev_req[owner_q] ||
                             (hold_q == HOLD_LAST && !dev_stb[owner_q])) begin
                    // Timeout never cuts a strobe that is still high.
                    state_d = S_REL;
                    gnt_d   = '0;
                end
            end

            S_REL: begin
                if (!dma_ack) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // dma_req is a pure function of the next state, so it is registered
        // and has no combinational path from dma_ack.
        req_d = (state_d == S_REQ) || (state_d == S_OWN);
    end

    always_ff @(posedge clk_p) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (dclo) begin
            state_q <= S_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= '0;
            gnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
        end
    end

    // Combinational datapath: zero added latency through the owner mux.
    assign dev_gnt   = gnt_q;
    assign dma_req   = req_q;
    assign dma_adr18 = (gnt_q != 4'd0) ? dev_adr[int'(owner_q) * 18 +: 18] : 18'd0;
    assign dma_stb   = dev_stb[owner_q] & gnt_q[owner_q];
    assign dev_ack   = {4{global_ack}} & gnt_q;

endmodule
